cfg_loader: RTL

Serial configuration loader for the FPGA fabric. It receives a configuration bitstream one bit per valid cycle, finds a sync word, and assembles the following 32-bit configuration words. Each completed word is written to an indexed configuration slot: LUT, LUT-memory, switch-box, connection-box, I/O and output-mux images. This replaces backdoor loading of the fabric's configuration memories. It sits between the external configuration pin pair and the fabric's configuration write port, and signals completion or error.

---
 rtl/cfg_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cfg_loader.sv
// cfg_loader: serial configuration loader for the FPGA fabric.
// Hunts for a sync word on the serial input. It then assembles NWORDS
// configuration words, MSB first, and writes each one to its indexed slot.
// Optional feature macro: CFG_CHECKSUM_EN. When it is defined, a trailing
// checksum word (the wrapping sum of all data words) is required after the
// last data word. A mismatch ends the frame in a sticky error state.
module cfg_loader #(
    parameter int                NWORDS = 8,
    parameter int                WIDTH  = 32,
    parameter logic [WIDTH-1:0]  SYNC   = 32'hA5C3F00D
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cin,
    input  logic                       cvalid,
    output logic                       wr_en,
    output logic [$clog2(NWORDS)-1:0]  wr_addr,
    output logic [WIDTH-1:0]           wr_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int AW = $clog2(NWORDS);
    localparam int IW = AW + 1;
    localparam int BW = $clog2(WIDTH);

    localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);

`ifdef CFG_CHECKSUM_EN
    typedef enum logic [2:0] {HUNT, LOAD, CHECK, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {HUNT, LOAD, DONE} state_t;
`endif

    state_t            state_r;
    state_t            state_n;
    logic [WIDTH-1:0]  sr_r;
    logic [WIDTH-1:0]  word_r;
    logic [BW-1:0]     bit_cnt_r;
    logic [IW-1:0]     idx_r;
    logic              wr_en_r;
    logic [AW-1:0]     wr_addr_r;
    logic [WIDTH-1:0]  wr_data_r;
    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  sr_s;
    logic [WIDTH-1:0]  word_s;
    logic              last_bit_s;
    logic              last_word_s;
`ifdef CFG_CHECKSUM_EN
    logic [WIDTH-1:0]  sum_r;
    logic              err_r;
`endif

    // Next-state decode; shifted views of the sync and word registers.
    always_comb begin
        state_n     = state_r;
        sr_s        = {sr_r[WIDTH-2:0], cin};
        word_s      = {word_r[WIDTH-2:0], cin};
        last_bit_s  = (bit_cnt_r == BIT_LAST);
        last_word_s = (idx_r == IDX_LAST);
        case (state_r)
            HUNT: begin
                if (cvalid && (sr_s == SYNC)) state_n = LOAD;
                else                          state_n = HUNT;
            end
            LOAD: begin
                if (cvalid && last_bit_s && last_word_s) begin
`ifdef CFG_CHECKSUM_EN
                    state_n = CHECK;
`else
                    state_n = DONE;
`endif
                end else begin
                    state_n = LOAD;
                end
            end
`ifdef CFG_CHECKSUM_EN
            CHECK: begin
                if (cvalid && last_bit_s) state_n = (word_s == sum_r) ? DONE : ERR;
                else                      state_n = CHECK;
            end
            ERR:     state_n = ERR;
`endif
            DONE:    state_n = DONE;
            default: state_n = HUNT;
        endcase
    end

    // State register, datapath shifting/counting and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= HUNT;
            sr_r      <= {WIDTH{1'b0}};
            word_r    <= {WIDTH{1'b0}};
            bit_cnt_r <= BIT_ZERO;
            idx_r     <= IDX_ZERO;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            sum_r     <= {WIDTH{1'b0}};
            err_r     <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            wr_en_r <= 1'b0;
            done_r  <= (state_n == DONE);
`ifdef CFG_CHECKSUM_EN
            busy_r  <= (state_n == LOAD) || (state_n == CHECK);
            err_r   <= (state_n == ERR);
`else
            busy_r  <= (state_n == LOAD);
`endif
            if (cvalid) begin
                case (state_r)
                    HUNT: begin
                        sr_r <= sr_s;
                        if (state_n == LOAD) begin
                            bit_cnt_r <= BIT_ZERO;
                            idx_r     <= IDX_ZERO;
                            word_r    <= {WIDTH{1'b0}};
`ifdef CFG_CHECKSUM_EN
                            sum_r     <= {WIDTH{1'b0}};
`endif
                        end
                    end
                    LOAD: begin
                        word_r <= word_s;
                        if (last_bit_s) begin
                            bit_cnt_r <= BIT_ZERO;
                            idx_r     <= idx_r + IDX_ONE;
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= idx_r[AW-1:0];
                            wr_data_r <= word_s;
`ifdef CFG_CHECKSUM_EN
                            sum_r     <= sum_r + word_s;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        end
                    end
`ifdef CFG_CHECKSUM_EN
                    CHECK: begin
                        word_r <= word_s;
                        if (last_bit_s) bit_cnt_r <= BIT_ZERO;
                        else            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign busy    = busy_r;
    assign done    = done_r;
`ifdef CFG_CHECKSUM_EN
    assign err     = err_r;
`else
    assign err     = 1'b0;
`endif

endmodule
